// File: rtl/sensor_debouncer.sv
// Two-flop synchroniser, shared sample-tick prescaler and per-channel stability counters
// that turn bouncy field-sensor lines into clean levels, change pulses and a ready flag.
module sensor_debouncer #(
  parameter int CHANNELS     = 6,
  parameter int PRESCALE     = 1000,
  parameter int STABLE_TICKS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_sensors,
  output logic [CHANNELS-1:0] clean_sensors,
  output logic [CHANNELS-1:0] changed,
  output logic                ready
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PS_LAST  = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(STABLE_TICKS);

  logic [CHANNELS-1:0] sync_a;
  logic [CHANNELS-1:0] sync_b;
  logic [PW-1:0]       ps_cnt;
  logic                tick;
  logic [CW-1:0]       tick_cnt;
  logic [CW-1:0]       cnt [CHANNELS];

  assign tick = (ps_cnt == PS_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw_sensors;
      sync_b <= sync_a;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ps_cnt   <= '0;
      tick_cnt <= '0;
      ready    <= 1'b0;
    end else begin
      ps_cnt <= tick ? '0 : ps_cnt + PW'(1);
      if (tick) begin
        if (tick_cnt != CNT_FULL) tick_cnt <= tick_cnt + CW'(1);
        if (tick_cnt == CNT_LAST) ready <= 1'b1;
      end
    end
  end

  // Any tick that samples the current clean level throws away accumulated progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      clean_sensors <= '0;
      changed       <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      changed <= '0;
      if (tick) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (sync_b[i] == clean_sensors[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_LAST) begin
            clean_sensors[i] <= sync_b[i];
            changed[i]       <= 1'b1;
            cnt[i]           <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sensor_debouncer.sv
// Bench for sensor_debouncer: directed vector table, hand-written corner sequences and
// randomized stimulus compared every clock against a sample-history reference model.
module tb_sensor_debouncer;

  localparam int CH = 6;
  localparam int PS = 4;
  localparam int ST = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] raw_sensors = '0;
  logic [CH-1:0] clean_sensors;
  logic [CH-1:0] changed;
  logic          ready;

  int checks   = 0;
  int failures = 0;
  int e        = 0;

  sensor_debouncer #(
    .CHANNELS(CH),
    .PRESCALE(PS),
    .STABLE_TICKS(ST)
  ) dut (
    .clock(clock),
    .reset(reset),
    .raw_sensors(raw_sensors),
    .clean_sensors(clean_sensors),
    .changed(changed),
    .ready(ready)
  );

  always #5 clock = ~clock;

  // Reference model: raw delayed two clocks, ticks every PS clocks since reset release,
  // a channel flips once the last ST samples since its last flip all differ from it.
  logic [CH-1:0] sq[$] = '{6'b0, 6'b0};
  logic [CH-1:0] samples[$];
  int            last_upd [CH];
  logic [CH-1:0] m_clean   = '0;
  logic [CH-1:0] m_changed = '0;
  logic          m_ready   = 1'b0;
  int            m_ticks   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at edge %0d t=%0t", name, act, exp, e, $time);
    end
  endtask

  task automatic model_update();
    logic [CH-1:0] s;
    logic [CH-1:0] smp;
    int idx;
    bit ok;
    if (reset) begin
      sq = '{6'b0, 6'b0};
      samples.delete();
      for (int c = 0; c < CH; c++) last_upd[c] = -1;
      m_clean = '0; m_changed = '0; m_ready = 1'b0; m_ticks = 0; e = 0;
    end else begin
      e++;
      s = sq[0];
      void'(sq.pop_front());
      sq.push_back(raw_sensors);
      m_changed = '0;
      if (e % PS == 0) begin
        m_ticks++;
        if (m_ticks >= ST) m_ready = 1'b1;
        samples.push_back(s);
        idx = samples.size() - 1;
        for (int c = 0; c < CH; c++) begin
          if (idx - last_upd[c] >= ST) begin
            ok = 1'b1;
            for (int k = 0; k < ST; k++) begin
              smp = samples[idx-k];
              if (smp[c] == m_clean[c]) ok = 1'b0;
            end
            if (ok) begin
              m_clean[c]   = ~m_clean[c];
              m_changed[c] = 1'b1;
              last_upd[c]  = idx;
            end
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_update();
    #1;
    chk("model_clean", 32'(clean_sensors), 32'(m_clean));
    chk("model_changed", 32'(changed), 32'(m_changed));
    chk("model_ready", 32'(ready), 32'(m_ready));
  endtask

  typedef struct {
    int            at_edge;
    logic [CH-1:0] raw;
    logic [CH-1:0] clean;
    logic [CH-1:0] chg;
    logic          rdy;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hold;
    tbl[0]  = '{0,  6'b000000, 6'b000000, 6'b000000, 1'b0};
    tbl[1]  = '{3,  6'b000000, 6'b000000, 6'b000000, 1'b0};
    tbl[2]  = '{4,  6'b000000, 6'b000000, 6'b000000, 1'b0};
    tbl[3]  = '{11, 6'b000000, 6'b000000, 6'b000000, 1'b0};
    tbl[4]  = '{12, 6'b000000, 6'b000000, 6'b000000, 1'b1};
    tbl[5]  = '{19, 6'b000000, 6'b000000, 6'b000000, 1'b1};
    tbl[6]  = '{20, 6'b001100, 6'b000000, 6'b000000, 1'b1};
    tbl[7]  = '{24, 6'b001100, 6'b000000, 6'b000000, 1'b1};
    tbl[8]  = '{25, 6'b000100, 6'b000000, 6'b000000, 1'b1};
    tbl[9]  = '{28, 6'b000100, 6'b000000, 6'b000000, 1'b1};
    tbl[10] = '{31, 6'b000100, 6'b000000, 6'b000000, 1'b1};
    tbl[11] = '{32, 6'b000100, 6'b000100, 6'b000100, 1'b1};
    tbl[12] = '{33, 6'b000100, 6'b000100, 6'b000000, 1'b1};
    tbl[13] = '{44, 6'b000100, 6'b000100, 6'b000000, 1'b1};

    // Reset for 3 clocks, then walk the vector table.
    reset = 1'b1; raw_sensors = '0;
    repeat (3) cycle();
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      n = 0;
      while (e < tbl[i].at_edge && n < 100) begin cycle(); n++; end
      chk("tbl_clean", 32'(clean_sensors), 32'(tbl[i].clean));
      chk("tbl_changed", 32'(changed), 32'(tbl[i].chg));
      chk("tbl_ready", 32'(ready), 32'(tbl[i].rdy));
      raw_sensors = tbl[i].raw;
    end

    // Re-asserted reset drops ready on the next edge.
    reset = 1'b1; raw_sensors = '0;
    cycle();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_clean", 32'(clean_sensors), 32'd0);
    reset = 1'b0;

    // raw[0] chatter every 2 clocks, phased so every tick samples a low.
    for (int j = 0; j < 60; j++) begin
      raw_sensors[0] = e[1];
      cycle();
      chk("chatter_clean", 32'(clean_sensors[0]), 32'd0);
      chk("chatter_changed", 32'(changed), 32'd0);
    end
    raw_sensors[0] = 1'b1;
    for (n = 0; n < 2 + ST*PS && !clean_sensors[0]; n++) cycle();
    chk("chatter_settle", 32'(clean_sensors[0]), 32'd1);

    // All channels rise together, then bits 0,2,4 fall together.
    reset = 1'b1; raw_sensors = '0;
    cycle();
    reset = 1'b0;
    raw_sensors = 6'b111111;
    for (n = 0; n < 2 + ST*PS && clean_sensors == 6'b0; n++) cycle();
    chk("all_rise_clean", 32'(clean_sensors), 32'h3f);
    chk("all_rise_changed", 32'(changed), 32'h3f);
    cycle();
    chk("all_rise_pulse_end", 32'(changed), 32'd0);
    raw_sensors = 6'b101010;
    for (n = 0; n < 2 + ST*PS && clean_sensors == 6'b111111; n++) cycle();
    chk("even_fall_clean", 32'(clean_sensors), 32'h2a);
    chk("even_fall_changed", 32'(changed), 32'h15);

    // Reset after 2 counted ticks must discard the channel's progress.
    reset = 1'b1; raw_sensors = 6'b100000;
    cycle();
    reset = 1'b0;
    while (e < 8) cycle();
    chk("midrst_before", 32'(clean_sensors), 32'd0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    while (e < 11) cycle();
    chk("midrst_no_early", 32'(clean_sensors), 32'd0);
    cycle();
    chk("midrst_rise_clean", 32'(clean_sensors), 32'h20);
    chk("midrst_rise_changed", 32'(changed), 32'h20);

    // Randomized segments with occasional resets, checked by the model every clock.
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        cycle();
        reset = 1'b0;
      end
      raw_sensors = 6'($urandom());
      hold = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(12, 30))
                                         : 32'($urandom_range(1, 6));
      for (int h = 0; h < hold; h++) cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
